// File: rtl/mio_access_ctrl.sv
`timescale 1ns/1ps
// LC-3 MAR/MDR access sequencer: decodes memory vs KBSR/KBDR/DSR/DDR, runs the memory handshake
// and owns the keyboard/display device registers. o_R pulses in DONE; device access spends no cycle in MEM_WAIT.
module mio_access_ctrl #(
  parameter int          MEM_TIMEOUT = 16,
  parameter logic [15:0] KBSR_ADDR   = 16'hFE00,
  parameter logic [15:0] KBDR_ADDR   = 16'hFE02,
  parameter logic [15:0] DSR_ADDR    = 16'hFE04,
  parameter logic [15:0] DDR_ADDR    = 16'hFE06
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_MIO_EN,
  input  logic        i_R_W,
  input  logic [15:0] i_MAR,
  input  logic [15:0] i_MDR,
  output logic [15:0] o_MIO_Data,
  output logic        o_R,
  output logic        o_Err,
  output logic        o_Mem_Req,
  output logic        o_Mem_We,
  output logic [15:0] o_Mem_Addr,
  output logic [15:0] o_Mem_Wdata,
  input  logic        i_Mem_Ready,
  input  logic [15:0] i_Mem_Rdata,
  input  logic        i_Kbd_Valid,
  input  logic [7:0]  i_Kbd_Data,
  output logic        o_Kbd_Int,
  output logic        o_Dsp_Valid,
  output logic [7:0]  o_Dsp_Data,
  input  logic        i_Dsp_Ready
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic          we_q, err_q;
  logic [15:0]   addr_q, wdata_q, rdata_q;
  logic [CW-1:0] cnt;
  logic          kb_rdy, kb_ie, kb_ovr;
  logic [7:0]    kbdr;
  logic          dsr_rdy, dsp_vld;
  logic [15:0]   ddr;

  logic is_kbsr, is_kbdr, is_dsr, is_ddr, is_dev;
  logic accept, mem_timeout, kbdr_rd, kbsr_wr, kbd_take;
  logic [15:0] kbsr_val;

  assign is_kbsr     = (i_MAR == KBSR_ADDR);
  assign is_kbdr     = (i_MAR == KBDR_ADDR);
  assign is_dsr      = (i_MAR == DSR_ADDR);
  assign is_ddr      = (i_MAR == DDR_ADDR);
  assign is_dev      = is_kbsr | is_kbdr | is_dsr | is_ddr;
  assign accept      = (state == IDLE) && i_MIO_EN;
  assign mem_timeout = (cnt == CW'(MEM_TIMEOUT - 1));
  assign kbsr_val    = {kb_rdy, kb_ie, kb_ovr, 13'b0};
  assign kbdr_rd     = accept && is_kbdr && !i_R_W;
  assign kbsr_wr     = accept && is_kbsr && i_R_W;
  // A KBDR read on the same edge frees the buffer, so the incoming char is taken, not dropped.
  assign kbd_take    = i_Kbd_Valid && (!kb_rdy || kbdr_rd);

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (i_MIO_EN) state_nxt = is_dev ? DONE : MEM_WAIT;
      MEM_WAIT: if (i_Mem_Ready || mem_timeout) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_R        = 1'b0;
    o_Err      = 1'b0;
    o_MIO_Data = 16'h0000;
    o_Mem_Req  = 1'b0;
    o_Mem_We   = 1'b0;
    case (state)
      MEM_WAIT: begin
        o_Mem_Req = 1'b1;
        o_Mem_We  = we_q;
      end
      DONE: begin
        o_R        = 1'b1;
        o_Err      = err_q;
        o_MIO_Data = rdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      cnt     <= '0;
      kb_rdy  <= 1'b0;
      kb_ie   <= 1'b0;
      kb_ovr  <= 1'b0;
      kbdr    <= 8'h00;
      dsr_rdy <= 1'b1;
      dsp_vld <= 1'b0;
      ddr     <= 16'h0000;
    end else begin
      if (accept) begin
        we_q    <= i_R_W;
        addr_q  <= i_MAR;
        wdata_q <= i_MDR;
        cnt     <= '0;
        err_q   <= 1'b0;
        rdata_q <= 16'h0000;
        if (!i_R_W) begin
          if (is_kbsr)      rdata_q <= kbsr_val;
          else if (is_kbdr) rdata_q <= {8'h00, kbdr};
          else if (is_dsr)  rdata_q <= {dsr_rdy, 15'b0};
          else if (is_ddr)  rdata_q <= ddr;
        end else if (is_ddr) begin
          if (dsr_rdy) begin
            ddr     <= i_MDR;
            dsr_rdy <= 1'b0;
            dsp_vld <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
      end

      if (state == MEM_WAIT) begin
        if (i_Mem_Ready) begin
          rdata_q <= we_q ? 16'h0000 : i_Mem_Rdata;
        end else if (mem_timeout) begin
          err_q   <= 1'b1;
          rdata_q <= 16'h0000;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      if (kbd_take) begin
        kbdr   <= i_Kbd_Data;
        kb_rdy <= 1'b1;
      end else if (kbdr_rd) begin
        kb_rdy <= 1'b0;
      end
      if (kbsr_wr) begin
        kb_ie  <= i_MDR[14];
        kb_ovr <= 1'b0;
      end
      // A dropped char on the same edge as a KBSR write still records the overrun.
      if (i_Kbd_Valid && !kbd_take) kb_ovr <= 1'b1;

      if (dsp_vld && i_Dsp_Ready) begin
        dsp_vld <= 1'b0;
        dsr_rdy <= 1'b1;
      end
    end
  end

  assign o_Mem_Addr  = addr_q;
  assign o_Mem_Wdata = wdata_q;
  assign o_Kbd_Int   = kb_rdy & kb_ie;
  assign o_Dsp_Valid = dsp_vld;
  assign o_Dsp_Data  = ddr[7:0];

endmodule

// File: tb/tb_mio_access_ctrl.sv
`timescale 1ns/1ps
// Directed bench for mio_access_ctrl: vector table for device registers, hand sequences for memory and reset.
module tb_mio_access_ctrl;

  localparam logic [15:0] KBSR = 16'hFE00;
  localparam logic [15:0] KBDR = 16'hFE02;
  localparam logic [15:0] DSR  = 16'hFE04;
  localparam logic [15:0] DDR  = 16'hFE06;

  logic        i_Clk = 1'b0;
  logic        i_Rst_n;
  logic        i_MIO_EN, i_R_W;
  logic [15:0] i_MAR, i_MDR;
  logic [15:0] o_MIO_Data;
  logic        o_R, o_Err, o_Mem_Req, o_Mem_We;
  logic [15:0] o_Mem_Addr, o_Mem_Wdata;
  logic        i_Mem_Ready;
  logic [15:0] i_Mem_Rdata;
  logic        i_Kbd_Valid;
  logic [7:0]  i_Kbd_Data;
  logic        o_Kbd_Int, o_Dsp_Valid;
  logic [7:0]  o_Dsp_Data;
  logic        i_Dsp_Ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_Clk = ~i_Clk;

  mio_access_ctrl dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_MIO_EN(i_MIO_EN), .i_R_W(i_R_W),
    .i_MAR(i_MAR), .i_MDR(i_MDR), .o_MIO_Data(o_MIO_Data), .o_R(o_R), .o_Err(o_Err),
    .o_Mem_Req(o_Mem_Req), .o_Mem_We(o_Mem_We), .o_Mem_Addr(o_Mem_Addr),
    .o_Mem_Wdata(o_Mem_Wdata), .i_Mem_Ready(i_Mem_Ready), .i_Mem_Rdata(i_Mem_Rdata),
    .i_Kbd_Valid(i_Kbd_Valid), .i_Kbd_Data(i_Kbd_Data), .o_Kbd_Int(o_Kbd_Int),
    .o_Dsp_Valid(o_Dsp_Valid), .o_Dsp_Data(o_Dsp_Data), .i_Dsp_Ready(i_Dsp_Ready)
  );

  typedef struct {
    logic        kbd;   // pulse keyboard before the access
    logic [7:0]  kch;
    logic        rdy;   // pulse display ready before the access
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] ed;    // expected o_MIO_Data at o_R
    logic        ee;    // expected o_Err at o_R
    logic        ek;    // expected o_Kbd_Int after the access
    logic        ev;    // expected o_Dsp_Valid after the access
    logic [7:0]  edd;   // expected o_Dsp_Data when ev
  } vec_t;

  vec_t vt[21];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic kbd_pulse(input logic [7:0] ch);
    @(posedge i_Clk); #1;
    i_Kbd_Valid = 1'b1;
    i_Kbd_Data  = ch;
    @(posedge i_Clk); #1;
    i_Kbd_Valid = 1'b0;
  endtask

  task automatic dsp_pulse();
    @(posedge i_Clk); #1;
    i_Dsp_Ready = 1'b1;
    @(posedge i_Clk); #1;
    i_Dsp_Ready = 1'b0;
  endtask

  // lat counts falling edges from request until o_R; 0 means o_R never arrived.
  task automatic access(input logic rw, input logic [15:0] addr, input logic [15:0] wd,
                        input logic kbd_same, input logic [7:0] kch,
                        output logic [15:0] rd, output logic er, output int lat);
    @(posedge i_Clk); #1;
    i_MIO_EN = 1'b1;
    i_R_W    = rw;
    i_MAR    = addr;
    i_MDR    = wd;
    if (kbd_same) begin
      i_Kbd_Valid = 1'b1;
      i_Kbd_Data  = kch;
    end
    rd = 16'h0; er = 1'b0; lat = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge i_Clk);
      if (k == 1) i_Kbd_Valid = 1'b0;
      if (o_R) begin
        rd  = o_MIO_Data;
        er  = o_Err;
        lat = k + 1;
        break;
      end
    end
    @(posedge i_Clk); #1;
    i_MIO_EN    = 1'b0;
    i_Kbd_Valid = 1'b0;
  endtask

  initial begin
    logic [15:0] rd, d;
    logic        er, e, seen;
    int          lat, n;

    vt[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, KBSR, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, DSR,  16'h0000, 16'h8000, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, KBDR, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[3]  = '{1'b1, 8'h41, 1'b0, 1'b0, KBSR, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, KBDR, 16'h0000, 16'h0041, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, KBSR, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[6]  = '{1'b1, 8'h41, 1'b0, 1'b0, DSR,  16'h0000, 16'h8000, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[7]  = '{1'b1, 8'h42, 1'b0, 1'b0, KBSR, 16'h0000, 16'hA000, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, KBSR, 16'h4000, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, KBSR, 16'h0000, 16'hC000, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[10] = '{1'b0, 8'h00, 1'b0, 1'b0, KBDR, 16'h0000, 16'h0041, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[11] = '{1'b0, 8'h00, 1'b0, 1'b0, KBSR, 16'h0000, 16'h4000, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[12] = '{1'b0, 8'h00, 1'b0, 1'b1, DDR,  16'h0058, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h58};
    vt[13] = '{1'b0, 8'h00, 1'b0, 1'b0, DSR,  16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h58};
    vt[14] = '{1'b0, 8'h00, 1'b0, 1'b1, DDR,  16'h0077, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h58};
    vt[15] = '{1'b0, 8'h00, 1'b0, 1'b0, DDR,  16'h0000, 16'h0058, 1'b0, 1'b0, 1'b1, 8'h58};
    vt[16] = '{1'b0, 8'h00, 1'b1, 1'b0, DSR,  16'h0000, 16'h8000, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[17] = '{1'b0, 8'h00, 1'b0, 1'b1, KBDR, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[18] = '{1'b0, 8'h00, 1'b0, 1'b0, KBDR, 16'h0000, 16'h0041, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[19] = '{1'b0, 8'h00, 1'b0, 1'b1, DSR,  16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[20] = '{1'b0, 8'h00, 1'b0, 1'b0, DSR,  16'h0000, 16'h8000, 1'b0, 1'b0, 1'b0, 8'h00};

    i_Rst_n = 1'b0; i_MIO_EN = 1'b0; i_R_W = 1'b0; i_MAR = 16'h0; i_MDR = 16'h0;
    i_Mem_Ready = 1'b0; i_Mem_Rdata = 16'h0; i_Kbd_Valid = 1'b0; i_Kbd_Data = 8'h0;
    i_Dsp_Ready = 1'b0;
    repeat (3) @(posedge i_Clk);
    @(negedge i_Clk);
    chk("reset o_R",        {15'b0, o_R},       16'h0);
    chk("reset o_Err",      {15'b0, o_Err},     16'h0);
    chk("reset o_Mem_Req",  {15'b0, o_Mem_Req}, 16'h0);
    chk("reset o_Mem_Addr", o_Mem_Addr,         16'h0);
    chk("reset o_MIO_Data", o_MIO_Data,         16'h0);
    chk("reset o_Dsp_Valid",{15'b0, o_Dsp_Valid}, 16'h0);
    chk("reset o_Kbd_Int",  {15'b0, o_Kbd_Int}, 16'h0);
    @(posedge i_Clk); #1;
    i_Rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      if (vt[i].kbd) kbd_pulse(vt[i].kch);
      if (vt[i].rdy) dsp_pulse();
      access(vt[i].rw, vt[i].addr, vt[i].wd, 1'b0, 8'h00, rd, er, lat);
      chk($sformatf("vec%0d data", i),    rd,                 vt[i].ed);
      chk($sformatf("vec%0d err", i),     {15'b0, er},        {15'b0, vt[i].ee});
      chk($sformatf("vec%0d latency", i), 16'(lat),           16'd2);
      chk($sformatf("vec%0d kbd_int", i), {15'b0, o_Kbd_Int}, {15'b0, vt[i].ek});
      chk($sformatf("vec%0d dsp_vld", i), {15'b0, o_Dsp_Valid}, {15'b0, vt[i].ev});
      if (vt[i].ev) chk($sformatf("vec%0d dsp_dat", i), {8'h0, o_Dsp_Data}, {8'h0, vt[i].edd});
    end

    // KBDR read with a keyboard strobe on the same decode edge
    kbd_pulse(8'h43);
    access(1'b0, KBDR, 16'h0, 1'b1, 8'h44, rd, er, lat);
    chk("same-edge kbdr old", rd, 16'h0043);
    chk("same-edge kbd_int", {15'b0, o_Kbd_Int}, 16'h1);
    access(1'b0, KBSR, 16'h0, 1'b0, 8'h00, rd, er, lat);
    chk("same-edge kbsr", rd, 16'hC000);
    access(1'b0, KBDR, 16'h0, 1'b0, 8'h00, rd, er, lat);
    chk("same-edge kbdr new", rd, 16'h0044);

    // memory read, ready on the third request cycle
    @(posedge i_Clk); #1;
    i_MIO_EN = 1'b1; i_R_W = 1'b0; i_MAR = 16'h3000;
    @(negedge i_Clk);
    chk("mrd idle req", {15'b0, o_Mem_Req}, 16'h0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge i_Clk);
      chk($sformatf("mrd req c%0d", c), {15'b0, o_Mem_Req}, 16'h1);
      if (c == 3) begin
        i_Mem_Ready = 1'b1;
        i_Mem_Rdata = 16'h1234;
      end
    end
    chk("mrd addr", o_Mem_Addr, 16'h3000);
    chk("mrd we", {15'b0, o_Mem_We}, 16'h0);
    @(negedge i_Clk);
    i_Mem_Ready = 1'b0;
    chk("mrd o_R", {15'b0, o_R}, 16'h1);
    chk("mrd data", o_MIO_Data, 16'h1234);
    chk("mrd err", {15'b0, o_Err}, 16'h0);
    chk("mrd req drop", {15'b0, o_Mem_Req}, 16'h0);
    @(posedge i_Clk); #1;
    i_MIO_EN = 1'b0;
    @(negedge i_Clk);
    chk("mrd o_R pulse", {15'b0, o_R}, 16'h0);

    // memory read that never completes
    @(posedge i_Clk); #1;
    i_MIO_EN = 1'b1; i_R_W = 1'b0; i_MAR = 16'h4000;
    n = 0; seen = 1'b0; d = 16'hFFFF; e = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_Clk);
      if (o_R) begin
        seen = 1'b1; d = o_MIO_Data; e = o_Err;
        break;
      end
      if (o_Mem_Req) n++;
    end
    @(posedge i_Clk); #1;
    i_MIO_EN = 1'b0;
    chk("timeout o_R seen", {15'b0, seen}, 16'h1);
    chk("timeout req cycles", 16'(n), 16'd16);
    chk("timeout err", {15'b0, e}, 16'h1);
    chk("timeout data", d, 16'h0000);

    // memory write to an unlisted address just above the device block
    @(posedge i_Clk); #1;
    i_MIO_EN = 1'b1; i_R_W = 1'b1; i_MAR = 16'hFE08; i_MDR = 16'hBEEF;
    @(negedge i_Clk);
    @(negedge i_Clk);
    chk("mwr req", {15'b0, o_Mem_Req}, 16'h1);
    chk("mwr we", {15'b0, o_Mem_We}, 16'h1);
    chk("mwr addr", o_Mem_Addr, 16'hFE08);
    chk("mwr wdata", o_Mem_Wdata, 16'hBEEF);
    i_Mem_Ready = 1'b1; i_Mem_Rdata = 16'hFFFF;
    @(negedge i_Clk);
    i_Mem_Ready = 1'b0;
    chk("mwr o_R", {15'b0, o_R}, 16'h1);
    chk("mwr data", o_MIO_Data, 16'h0000);
    chk("mwr err", {15'b0, o_Err}, 16'h0);
    @(posedge i_Clk); #1;
    i_MIO_EN = 1'b0;

    // reset in the middle of a memory access, with the display busy
    access(1'b1, DDR, 16'h0061, 1'b0, 8'h00, rd, er, lat);
    chk("pre-rst dsp_vld", {15'b0, o_Dsp_Valid}, 16'h1);
    @(posedge i_Clk); #1;
    i_MIO_EN = 1'b1; i_R_W = 1'b0; i_MAR = 16'h5000;
    @(negedge i_Clk);
    @(negedge i_Clk);
    chk("pre-rst req", {15'b0, o_Mem_Req}, 16'h1);
    i_Rst_n = 1'b0;
    @(negedge i_Clk);
    chk("rst req", {15'b0, o_Mem_Req}, 16'h0);
    chk("rst o_R", {15'b0, o_R}, 16'h0);
    chk("rst dsp_vld", {15'b0, o_Dsp_Valid}, 16'h0);
    i_MIO_EN = 1'b0;
    @(posedge i_Clk); #1;
    i_Rst_n = 1'b1;
    access(1'b0, DSR, 16'h0, 1'b0, 8'h00, rd, er, lat);
    chk("post-rst dsr", rd, 16'h8000);
    access(1'b0, KBSR, 16'h0, 1'b0, 8'h00, rd, er, lat);
    chk("post-rst kbsr", rd, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
